// File: rtl/decoder_seq.sv
// decoder_seq: one-hot phase decoder/sequencer.
// A registered ENC_W-bit index drives a 2**ENC_W-bit one-hot output, gated
// combinationally by OE. The index can be loaded, stepped manually, or
// auto-run for CNT extra steps, with registered DONE and WRAP pulses.
module decoder_seq #(
    parameter int ENC_W   = 3,
    parameter int WRAP_AT = 2**ENC_W - 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ENC_W-1:0]      ENC,
    input  logic                  LOAD,
    input  logic                  STEP,
    input  logic                  START,
    input  logic [ENC_W-1:0]      CNT,
    input  logic                  HOLD,
    input  logic                  OE,
    output logic [2**ENC_W-1:0]   DEC,
    output logic [ENC_W-1:0]      IDX,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  WRAP
);

    localparam int DEC_W = 2**ENC_W;

    // Reject an out-of-range wrap point at elaboration.
    if (WRAP_AT < 0 || WRAP_AT > DEC_W - 1) begin : g_bad_wrap_at
        $error("decoder_seq: WRAP_AT must lie in 0..2**ENC_W-1");
    end

    localparam logic [ENC_W-1:0] WRAP_IDX = ENC_W'(WRAP_AT);
    localparam logic [ENC_W-1:0] IDX_ONE  = ENC_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [ENC_W-1:0] r_idx;
    logic [ENC_W-1:0] r_rem;
    logic             r_done;
    logic             r_wrap;

    logic [0:0]       w_state_d;
    logic [ENC_W-1:0] w_idx_d;
    logic [ENC_W-1:0] w_rem_d;
    logic             w_done_d;
    logic             w_wrap_d;
    logic [ENC_W-1:0] w_idx_next;
    logic             w_next_is_zero;

    // Successor of the current index, wrapping to 0 past WRAP_AT
    // (an index loaded above WRAP_AT also wraps on its next step).
    always_comb begin
        w_idx_next     = (r_idx >= WRAP_IDX) ? '0 : (r_idx + IDX_ONE);
        w_next_is_zero = (w_idx_next == '0);
    end

    // Next-state logic: IDLE priority START > LOAD > STEP; RUN ignores them.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_rem_d   = r_rem;
        w_done_d  = 1'b0;
        w_wrap_d  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_idx_d   = ENC;
                    w_rem_d   = CNT;
                    w_state_d = S_RUN;
                end else if (LOAD) begin
                    w_idx_d = ENC;
                end else if (STEP) begin
                    w_idx_d  = w_idx_next;
                    w_wrap_d = w_next_is_zero;
                end
            end
            S_RUN: begin
                if (!HOLD) begin
                    if (r_rem != '0) begin
                        w_idx_d  = w_idx_next;
                        w_rem_d  = r_rem - IDX_ONE;
                        w_wrap_d = w_next_is_zero;
                    end else begin
                        w_state_d = S_IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_rem   <= w_rem_d;
            r_done  <= w_done_d;
            r_wrap  <= w_wrap_d;
        end
    end

    // One-hot decode of the index, gated directly by OE with no register.
    always_comb begin
        DEC = '0;
        if (OE) begin
            DEC[r_idx] = 1'b1;
        end
    end

    // Status outputs come straight from the registers.
    always_comb begin
        IDX  = r_idx;
        BUSY = (r_state == S_RUN);
        DONE = r_done;
        WRAP = r_wrap;
    end

endmodule
